// File: rtl/instruction_cache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM state
// encoding, line/word geometry and the big-endian word extractor.
package instruction_cache_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    localparam int LINE_BITS        = 128;
    localparam int WORD_BITS        = 32;
    localparam int LINE_OFFSET_BITS = 4;

    // Word k of a line: byte base+4k sits in the top byte of the result.
    function automatic logic [WORD_BITS-1:0] word_of(
        input logic [LINE_BITS-1:0] line,
        input logic [1:0]           k
    );
        logic [WORD_BITS-1:0] word;
        case (k)
            2'd0:    word = line[127:96];
            2'd1:    word = line[95:64];
            2'd2:    word = line[63:32];
            default: word = line[31:0];
        endcase
        return word;
    endfunction

endpackage

// File: rtl/instruction_cache_if.sv
// Fetch-side and line-memory-side signals of the instruction cache.
// slave is the cache; master is the CPU plus line memory driving it.
interface instruction_cache_if;
    import instruction_cache_pkg::*;

    logic [31:0]          pc;
    logic                 pc_valid;
    logic [WORD_BITS-1:0] instruction;
    logic                 instruction_ready;
    logic                 stall;
    logic [31:0]          mem_address;
    logic [LINE_BITS-1:0] mem_data_line;

    modport slave (
        input  pc,
        input  pc_valid,
        input  mem_data_line,
        output instruction,
        output instruction_ready,
        output stall,
        output mem_address
    );

    modport master (
        output pc,
        output pc_valid,
        output mem_data_line,
        input  instruction,
        input  instruction_ready,
        input  stall,
        input  mem_address
    );

endinterface

// File: rtl/instruction_cache_line_store.sv
// Valid/tag/data storage for the cache: one combinational read port for the
// lookup, one synchronous write port for line fills. Only valid bits reset.
module icache_line_store
    import instruction_cache_pkg::*;
#(
    parameter int NUM_LINES = 8,
    parameter int IW        = 3,
    parameter int TAG_BITS  = 25
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [IW-1:0]        rd_index,
    output logic                 rd_valid,
    output logic [TAG_BITS-1:0]  rd_tag,
    output logic [LINE_BITS-1:0] rd_line,
    input  logic                 wr_en,
    input  logic [IW-1:0]        wr_index,
    input  logic [TAG_BITS-1:0]  wr_tag,
    input  logic [LINE_BITS-1:0] wr_line
);

    logic [NUM_LINES-1:0] valid_reg;
    logic [TAG_BITS-1:0]  tag_array  [NUM_LINES];
    logic [LINE_BITS-1:0] data_array [NUM_LINES];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LINES; gi++) begin : g_valid
            // Per-line valid bit: cleared by reset, set when its line is filled.
            always_ff @(posedge clock) begin
                if (reset) begin
                    valid_reg[gi] <= 1'b0;
                end else if (wr_en && (wr_index == IW'(gi))) begin
                    valid_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    // Tag and line data are left untouched by reset; valid gates their use.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            tag_array[wr_index]  <= wr_tag;
            data_array[wr_index] <= wr_line;
        end
    end

    assign rd_valid = valid_reg[rd_index];
    assign rd_tag   = tag_array[rd_index];
    assign rd_line  = data_array[rd_index];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped instruction cache: same-cycle hits, and on a miss a stall
// while a line-aligned address is held on the line memory for MEM_WAIT edges
// before the returned 128-bit line is written into the line store.
module instruction_cache
    import instruction_cache_pkg::*;
#(
    parameter int NUM_LINES = 8,
    parameter int MEM_WAIT  = 7
) (
    input logic                 clock,
    input logic                 reset,
    instruction_cache_if.slave  bus
);

    localparam int IW       = $clog2(NUM_LINES);
    localparam int TAG_BITS = 32 - LINE_OFFSET_BITS - IW;
    localparam int CW       = $clog2(MEM_WAIT + 1);

    state_t               state_reg, state_next;
    logic [CW-1:0]        count_reg;
    logic [31:0]          mem_address_reg;
    logic [IW-1:0]        fill_index_reg;
    logic [TAG_BITS-1:0]  fill_tag_reg;

    // The index sits just above the 16-byte line offset so that all four
    // words of a line share one entry.
    logic [1:0]           pc_offset;
    logic [IW-1:0]        pc_index;
    logic [TAG_BITS-1:0]  pc_tag;
    logic [1:0]           unused_pc_bits;

    logic                 rd_valid;
    logic [TAG_BITS-1:0]  rd_tag;
    logic [LINE_BITS-1:0] rd_line;
    logic                 hit;

    logic                 start_fill;
    logic                 capture;
    logic                 wr_en;
    logic [WORD_BITS-1:0] instruction_out;
    logic                 ready_out;
    logic                 stall_out;

    assign pc_offset      = bus.pc[3:2];
    assign pc_index       = bus.pc[LINE_OFFSET_BITS +: IW];
    assign pc_tag         = bus.pc[31 -: TAG_BITS];
    assign unused_pc_bits = bus.pc[1:0];

    icache_line_store #(
        .NUM_LINES (NUM_LINES),
        .IW        (IW),
        .TAG_BITS  (TAG_BITS)
    ) u_line_store (
        .clock    (clock),
        .reset    (reset),
        .rd_index (pc_index),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_line  (rd_line),
        .wr_en    (wr_en),
        .wr_index (fill_index_reg),
        .wr_tag   (fill_tag_reg),
        .wr_line  (bus.mem_data_line)
    );

    assign hit = bus.pc_valid && rd_valid && (rd_tag == pc_tag);

    // A reset landing on the capture edge must not leave a half-aborted write.
    assign wr_en = capture && !reset;

    // Next-state and fetch-side outputs: lookup in IDLE, wait out the memory in FILL.
    always_comb begin
        state_next      = state_reg;
        instruction_out = '0;
        ready_out       = 1'b0;
        stall_out       = 1'b0;
        start_fill      = 1'b0;
        capture         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.pc_valid) begin
                    if (hit) begin
                        ready_out       = 1'b1;
                        instruction_out = word_of(rd_line, pc_offset);
                    end else begin
                        stall_out  = 1'b1;
                        start_fill = 1'b1;
                        state_next = FILL;
                    end
                end
            end
            FILL: begin
                stall_out = 1'b1;
                if (count_reg == CW'(MEM_WAIT)) begin
                    capture    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, wait counter, memory address and latched fill target.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= IDLE;
            count_reg       <= '0;
            mem_address_reg <= '0;
            fill_index_reg  <= '0;
            fill_tag_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (start_fill) begin
                mem_address_reg <= {bus.pc[31:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
                fill_index_reg  <= pc_index;
                fill_tag_reg    <= pc_tag;
                count_reg       <= CW'(1);
            end else if (capture) begin
                count_reg <= '0;
            end else if (state_reg == FILL) begin
                count_reg <= count_reg + CW'(1);
            end
        end
    end

    assign bus.instruction       = instruction_out;
    assign bus.instruction_ready = ready_out;
    assign bus.stall             = stall_out;
    assign bus.mem_address       = mem_address_reg;

endmodule

// File: tb/tb_instruction_cache.sv
// Randomized self-checking bench for instruction_cache with a line-memory
// model (byte at address a is a[7:0]) and a transaction-level cache model.
module tb_instruction_cache;
    localparam int NUM_LINES = 8;
    localparam int MEM_WAIT  = 7;
    localparam logic [127:0] POISON = {4{32'hDEADBEEF}};

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    instruction_cache_if bus();

    instruction_cache #(
        .NUM_LINES (NUM_LINES),
        .MEM_WAIT  (MEM_WAIT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Line memory: the line becomes valid MEM_WAIT edges after its address changes.
    logic [31:0] mem_seen = '0;
    int          mem_age  = 1000;

    function automatic logic [127:0] line_at(input logic [31:0] a);
        logic [127:0] l;
        for (int i = 0; i < 16; i++) l[127 - 8*i -: 8] = 8'(a + 32'(i));
        return l;
    endfunction

    always @(negedge clock) begin
        if (bus.mem_address !== mem_seen) begin
            mem_seen = bus.mem_address;
            mem_age  = 1;
        end else if (mem_age < 1000) begin
            mem_age++;
        end
        bus.mem_data_line = (mem_age >= MEM_WAIT) ? line_at(mem_seen) : POISON;
    end

    // Reference cache contents: which line address each index holds.
    logic [31:0] ref_line  [NUM_LINES];
    bit          ref_valid [NUM_LINES];
    logic [31:0] exp_mem_address;

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        logic [31:0] b;
        b = a & ~32'h3;
        return {8'(b), 8'(b + 1), 8'(b + 2), 8'(b + 3)};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NUM_LINES; i++) ref_valid[i] = 1'b0;
        exp_mem_address = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.pc_valid = 1'b0;
        bus.pc = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        clear_model();
        @(negedge clock);
        check_eq("rst_stall", 32'(bus.stall), 32'd0);
        check_eq("rst_ready", 32'(bus.instruction_ready), 32'd0);
        check_eq("rst_addr", bus.mem_address, 32'h0);
        check_eq("rst_instr", bus.instruction, 32'h0);
        $display("reset: stall=%0d ready=%0d mem_address=%h", bus.stall, bus.instruction_ready, bus.mem_address);
        @(posedge clock);
        #1;
    endtask

    // One fetch, expected to hit or miss according to the reference model.
    task automatic fetch(input logic [31:0] a);
        logic [31:0] line;
        int          idx;
        bit          hit;
        int          n;
        line = a & ~32'hF;
        idx  = int'((a >> 4) % NUM_LINES);
        hit  = ref_valid[idx] && (ref_line[idx] == line);
        bus.pc = a;
        bus.pc_valid = 1'b1;
        @(negedge clock);
        n = 0;
        if (!hit) begin
            while (bus.stall === 1'b1 && n < 50) begin
                n++;
                check_eq("miss_ready", 32'(bus.instruction_ready), 32'd0);
                if (n >= 2) check_eq("miss_addr", bus.mem_address, line);
                @(negedge clock);
            end
            check_eq("miss_cycles", 32'(n), 32'(MEM_WAIT + 1));
            ref_valid[idx]  = 1'b1;
            ref_line[idx]   = line;
            exp_mem_address = line;
        end
        check_eq("ready", 32'(bus.instruction_ready), 32'd1);
        check_eq("stall", 32'(bus.stall), 32'd0);
        check_eq("word", bus.instruction, exp_word(a));
        $display("fetch pc=%h %s stall_cycles=%0d instr=%h expect=%h",
                 a, hit ? "hit " : "miss", n, bus.instruction, exp_word(a));
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int cycles);
        bus.pc_valid = 1'b0;
        bus.pc = $urandom;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            check_eq("idle_ready", 32'(bus.instruction_ready), 32'd0);
            check_eq("idle_stall", 32'(bus.stall), 32'd0);
            check_eq("idle_instr", bus.instruction, 32'h0);
            check_eq("idle_addr", bus.mem_address, exp_mem_address);
            @(posedge clock);
            #1;
        end
        $display("idle %0d cycles: mem_address=%h", cycles, bus.mem_address);
    endtask

    // Start a miss to a, then reset during the third FILL cycle.
    task automatic reset_mid_fill(input logic [31:0] a);
        bus.pc = a;
        bus.pc_valid = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        bus.pc_valid = 1'b0;
        @(posedge clock);
        #1 reset = 1'b0;
        clear_model();
        @(negedge clock);
        check_eq("abort_stall", 32'(bus.stall), 32'd0);
        check_eq("abort_addr", bus.mem_address, 32'h0);
        check_eq("abort_ready", 32'(bus.instruction_ready), 32'd0);
        $display("reset mid-fill pc=%h: stall=%0d mem_address=%h", a, bus.stall, bus.mem_address);
        @(posedge clock);
        #1;
    endtask

    initial begin
        bus.pc = '0;
        bus.pc_valid = 1'b0;
        do_reset();
        fetch(32'h00);
        fetch(32'h04);
        fetch(32'h08);
        fetch(32'h0C);
        fetch(32'h80);
        fetch(32'h00);
        idle(10);
        reset_mid_fill(32'h80);
        fetch(32'h00);
        fetch(32'h80);
        for (int t = 0; t < 40; t++) begin
            logic [31:0] a;
            a = (32'($urandom_range(0, 23)) << 4) | 32'($urandom_range(0, 15));
            fetch(a);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
